// File: rtl/pixel_region_logic_param.sv
// rtl/pixel_region_logic_param.sv - pixel region: hit time-stamping, ToT, latency buffer and token readout
// Optional lost-hit counter is built when PIXREG_OVFCNT_EN is defined.
module pixel_region_logic_param #(
    parameter int NPIX      = 4,
    parameter int TOT_W     = 4,
    parameter int MEM_DEPTH = 8,
    parameter int LAT_W     = 9,
    parameter int TRIG_W    = 5
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [NPIX-1:0]         Hit,
    input  logic [NPIX-1:0]         PwrDwn,
    input  logic [LAT_W-1:0]        LatCnt,
    input  logic [LAT_W-1:0]        LatCntReq,
    input  logic                    L1Trig,
    input  logic [TRIG_W-1:0]       TrigId,
    input  logic [TRIG_W-1:0]       TrigIdReq,
    input  logic                    Read,
    input  logic                    TokIn,
    output logic                    TokOut,
    output logic [NPIX*TOT_W-1:0]   DataToCore,
    output logic [7:0]              OvfCnt
);

    localparam int SW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    typedef enum logic [1:0] {S_FREE, S_WAIT, S_TRIG} slot_state_e;

    slot_state_e             st_q   [MEM_DEPTH];
    slot_state_e             st_d   [MEM_DEPTH];
    logic [LAT_W-1:0]        ts_q   [MEM_DEPTH];
    logic [LAT_W-1:0]        ts_d   [MEM_DEPTH];
    logic [TRIG_W-1:0]       tid_q  [MEM_DEPTH];
    logic [TRIG_W-1:0]       tid_d  [MEM_DEPTH];
    logic [NPIX-1:0]         mask_q [MEM_DEPTH];
    logic [NPIX-1:0]         mask_d [MEM_DEPTH];
    logic [TOT_W-1:0]        tot_q  [MEM_DEPTH][NPIX];
    logic [TOT_W-1:0]        tot_d  [MEM_DEPTH][NPIX];

    // Per-pixel link to the slot whose ToT the pixel is still counting
    logic [NPIX-1:0]         active_q, active_d;
    logic [SW-1:0]           cur_q  [NPIX];
    logic [SW-1:0]           cur_d  [NPIX];
    logic [NPIX-1:0]         hit_q;

    logic [NPIX-1:0]         hit_m, le;
    logic                    region_off;
    logic                    free_any, pend_any, alloc_en, alloc_fail, rd_en;
    logic [SW-1:0]           alloc_idx, rd_idx;
    logic [MEM_DEPTH-1:0]    expire;
    logic [LAT_W-1:0]        age;

    assign region_off = &PwrDwn;
    assign hit_m      = Hit & ~PwrDwn;
    assign le         = hit_m & ~hit_q;

    always_comb begin
        free_any  = 1'b0;
        alloc_idx = '0;
        pend_any  = 1'b0;
        rd_idx    = '0;
        expire    = '0;
        age       = '0;
        for (int i = MEM_DEPTH - 1; i >= 0; i--) begin
            if (st_q[i] == S_FREE) begin
                free_any  = 1'b1;
                alloc_idx = SW'(i);
            end
            if (st_q[i] == S_TRIG && tid_q[i] == TrigIdReq && !region_off) begin
                pend_any = 1'b1;
                rd_idx   = SW'(i);
            end
        end
        for (int i = 0; i < MEM_DEPTH; i++) begin
            age       = LatCnt - ts_q[i];
            expire[i] = (st_q[i] == S_WAIT) && (age == LatCntReq);
        end
    end

    assign alloc_en   = (|le) && free_any && !region_off;
    assign alloc_fail = (|le) && !free_any && !region_off;
    assign rd_en      = Read && !TokIn && pend_any;
    assign TokOut     = TokIn | pend_any;

    always_comb begin
        DataToCore = '0;
        if (rd_en) begin
            for (int p = 0; p < NPIX; p++) begin
                DataToCore[p*TOT_W +: TOT_W] = tot_q[rd_idx][p] & {TOT_W{mask_q[rd_idx][p]}};
            end
        end
    end

    always_comb begin
        st_d     = st_q;
        ts_d     = ts_q;
        tid_d    = tid_q;
        mask_d   = mask_q;
        tot_d    = tot_q;
        active_d = active_q;
        cur_d    = cur_q;

        for (int i = 0; i < MEM_DEPTH; i++) begin
            if (expire[i]) begin
                if (L1Trig) begin
                    st_d[i]  = S_TRIG;
                    tid_d[i] = TrigId;
                end else begin
                    st_d[i]   = S_FREE;
                    ts_d[i]   = '0;
                    tid_d[i]  = '0;
                    mask_d[i] = '0;
                    for (int p = 0; p < NPIX; p++) tot_d[i][p] = '0;
                end
            end
            if (rd_en && rd_idx == SW'(i)) begin
                st_d[i]   = S_FREE;
                ts_d[i]   = '0;
                tid_d[i]  = '0;
                mask_d[i] = '0;
                for (int p = 0; p < NPIX; p++) tot_d[i][p] = '0;
            end
        end

        // ToT counts only while the owning slot is in WAIT and not leaving it this cycle
        for (int p = 0; p < NPIX; p++) begin
            if (active_q[p]) begin
                if (!hit_m[p] || st_q[cur_q[p]] != S_WAIT || expire[cur_q[p]]) begin
                    active_d[p] = 1'b0;
                end else if (tot_q[cur_q[p]][p] != {TOT_W{1'b1}}) begin
                    tot_d[cur_q[p]][p] = tot_q[cur_q[p]][p] + TOT_W'(1);
                end
            end
        end

        if (alloc_en) begin
            st_d[alloc_idx]   = S_WAIT;
            ts_d[alloc_idx]   = LatCnt;
            tid_d[alloc_idx]  = '0;
            mask_d[alloc_idx] = le;
            for (int p = 0; p < NPIX; p++) begin
                tot_d[alloc_idx][p] = le[p] ? TOT_W'(1) : '0;
            end
        end
        for (int p = 0; p < NPIX; p++) begin
            if (le[p]) begin
                active_d[p] = alloc_en;
                cur_d[p]    = alloc_idx;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                st_q[i]   <= S_FREE;
                ts_q[i]   <= '0;
                tid_q[i]  <= '0;
                mask_q[i] <= '0;
                for (int p = 0; p < NPIX; p++) tot_q[i][p] <= '0;
            end
            for (int p = 0; p < NPIX; p++) cur_q[p] <= '0;
            active_q <= '0;
            hit_q    <= '0;
        end else begin
            st_q     <= st_d;
            ts_q     <= ts_d;
            tid_q    <= tid_d;
            mask_q   <= mask_d;
            tot_q    <= tot_d;
            cur_q    <= cur_d;
            active_q <= active_d;
            hit_q    <= hit_m;
        end
    end

`ifdef PIXREG_OVFCNT_EN
    logic [7:0] ovf_q, ovf_d;
    logic [9:0] lost, ovf_sum;

    always_comb begin
        lost = '0;
        for (int p = 0; p < NPIX; p++) lost = lost + 10'(le[p]);
        ovf_sum = {2'b00, ovf_q} + lost;
        ovf_d   = ovf_q;
        if (alloc_fail) ovf_d = (ovf_sum > 10'd255) ? 8'hFF : ovf_sum[7:0];
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) ovf_q <= '0;
        else        ovf_q <= ovf_d;
    end

    assign OvfCnt = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = alloc_fail;
    assign OvfCnt     = '0;
`endif

endmodule

// File: tb/tb_pixel_region_logic_param.sv
// tb/tb_pixel_region_logic_param.sv - directed self-checking bench for pixel_region_logic_param
module tb_pixel_region_logic_param;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  hit, hit_up, pwr;
    logic [8:0]  lat, lat_req;
    logic        l1;
    logic [4:0]  tid, trig_req;
    logic        rd, tok_in, chain;
    logic        tok_out, tok_up;
    logic [15:0] data_dn, data_up;
    logic [7:0]  ovf, ovf_up;
    logic        dn_tokin;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign dn_tokin = chain ? tok_up : tok_in;

    pixel_region_logic_param u_up (
        .Clk(clk), .Reset(rst_n), .Hit(hit_up), .PwrDwn(4'h0), .LatCnt(lat),
        .LatCntReq(lat_req), .L1Trig(l1), .TrigId(tid), .TrigIdReq(trig_req),
        .Read(rd), .TokIn(1'b0), .TokOut(tok_up), .DataToCore(data_up), .OvfCnt(ovf_up)
    );

    pixel_region_logic_param dut (
        .Clk(clk), .Reset(rst_n), .Hit(hit), .PwrDwn(pwr), .LatCnt(lat),
        .LatCntReq(lat_req), .L1Trig(l1), .TrigId(tid), .TrigIdReq(trig_req),
        .Read(rd), .TokIn(dn_tokin), .TokOut(tok_out), .DataToCore(data_dn), .OvfCnt(ovf)
    );

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        lat = lat + 9'd1;
    endtask

    task automatic run_to(input logic [8:0] v);
        int n = 0;
        while (lat !== v && n < 600) begin
            cyc();
            n++;
        end
        if (lat !== v) begin
            $display("FAIL run_to: lat=%0d required %0d", lat, v);
            errors++;
            checks++;
        end
    endtask

    task automatic trigger_at(input logic [8:0] v, input logic [4:0] id);
        run_to(v);
        l1 = 1'b1;
        tid = id;
        cyc();
        l1 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; hit = '0; hit_up = '0; pwr = '0; lat = '0; lat_req = 9'd20;
        l1 = 1'b0; tid = '0; trig_req = '0; rd = 1'b0; tok_in = 1'b1; chain = 1'b0;
        @(negedge clk);
        checks++; if (tok_out !== 1'b1) begin $display("FAIL reset_tokout_follow1: got %b want 1", tok_out); errors++; end
        checks++; if (data_dn !== 16'h0) begin $display("FAIL reset_data: got %h want 0000", data_dn); errors++; end
        checks++; if (ovf !== 8'h0) begin $display("FAIL reset_ovf: got %0d want 0", ovf); errors++; end
        tok_in = 1'b0;
        #1;
        checks++; if (tok_out !== 1'b0) begin $display("FAIL reset_tokout_follow0: got %b want 0", tok_out); errors++; end
        @(negedge clk);
        rst_n = 1'b1;
        lat = '0;
    endtask

    task automatic test_single_hit();
        run_to(9'd10);
        hit = 4'h4;
        run_to(9'd13);
        hit = 4'h0;
        trigger_at(9'd30, 5'd7);
        trig_req = 5'd7;
        #1;
        checks++; if (tok_out !== 1'b1) begin $display("FAIL single_pend: got %b want 1", tok_out); errors++; end
        checks++; if (data_dn !== 16'h0) begin $display("FAIL single_noread_data: got %h want 0000", data_dn); errors++; end
        rd = 1'b1;
        #1;
        checks++; if (data_dn !== 16'h0300) begin $display("FAIL single_data: got %h want 0300", data_dn); errors++; end
        cyc();
        rd = 1'b0;
        checks++; if (tok_out !== 1'b0) begin $display("FAIL single_freed: got %b want 0", tok_out); errors++; end
    endtask

    task automatic test_expiry();
        logic bad = 1'b0;
        trig_req = 5'd0;
        run_to(9'd40);
        hit = 4'h4;
        run_to(9'd43);
        hit = 4'h0;
        while (lat != 9'd62) begin
            if (tok_out !== 1'b0) bad = 1'b1;
            cyc();
        end
        checks++; if (bad !== 1'b0) begin $display("FAIL expiry_tokout: got pending want none"); errors++; end
    endtask

    task automatic test_shared_slot();
        run_to(9'd100);
        hit = 4'h9;
        run_to(9'd102);
        hit = 4'h8;
        run_to(9'd105);
        hit = 4'h0;
        trigger_at(9'd120, 5'd3);
        trig_req = 5'd3;
        rd = 1'b1;
        #1;
        checks++; if (data_dn !== 16'h5002) begin $display("FAIL shared_data: got %h want 5002", data_dn); errors++; end
        cyc();
        rd = 1'b0;
        checks++; if (tok_out !== 1'b0) begin $display("FAIL shared_one_slot: got %b want 0", tok_out); errors++; end
    endtask

    task automatic test_full();
        logic [7:0] ovf_exp;
`ifdef PIXREG_OVFCNT_EN
        ovf_exp = 8'd1;
`else
        ovf_exp = 8'd0;
`endif
        run_to(9'd200);
        for (int k = 0; k < 9; k++) begin
            hit = 4'h1;
            cyc();
            hit = 4'h0;
            cyc();
        end
        checks++; if (ovf !== ovf_exp) begin $display("FAIL full_ovf: got %0d want %0d", ovf, ovf_exp); errors++; end
        for (int k = 0; k < 9; k++) trigger_at(9'(220 + 2 * k), 5'(k));
        rd = 1'b1;
        for (int k = 0; k < 8; k++) begin
            trig_req = 5'(k);
            #1;
            checks++; if (tok_out !== 1'b1) begin $display("FAIL full_pend_%0d: got %b want 1", k, tok_out); errors++; end
            checks++; if (data_dn !== 16'h0001) begin $display("FAIL full_data_%0d: got %h want 0001", k, data_dn); errors++; end
            cyc();
        end
        rd = 1'b0;
        trig_req = 5'd8;
        #1;
        checks++; if (tok_out !== 1'b0) begin $display("FAIL full_dropped: got %b want 0", tok_out); errors++; end
    endtask

    task automatic test_saturate();
        run_to(9'd300);
        hit = 4'h2;
        run_to(9'd320);
        hit = 4'h0;
        l1 = 1'b1;
        tid = 5'd9;
        cyc();
        l1 = 1'b0;
        trig_req = 5'd9;
        rd = 1'b1;
        #1;
        checks++; if (data_dn !== 16'h00F0) begin $display("FAIL sat_data: got %h want 00f0", data_dn); errors++; end
        cyc();
        rd = 1'b0;
    endtask

    task automatic test_pwrdwn();
        run_to(9'd350);
        pwr = 4'hF;
        hit = 4'h1;
        tok_in = 1'b1;
        #1;
        checks++; if (tok_out !== 1'b1) begin $display("FAIL pwr_tok1: got %b want 1", tok_out); errors++; end
        run_to(9'd353);
        tok_in = 1'b0;
        #1;
        checks++; if (tok_out !== 1'b0) begin $display("FAIL pwr_tok0: got %b want 0", tok_out); errors++; end
        hit = 4'h0;
        cyc();
        pwr = 4'h0;
        trigger_at(9'd370, 5'd4);
        trig_req = 5'd4;
        #1;
        checks++; if (tok_out !== 1'b0) begin $display("FAIL pwr_noslot: got %b want 0", tok_out); errors++; end
    endtask

    task automatic test_back_to_back_chain();
        run_to(9'd400);
        hit = 4'h1;
        hit_up = 4'h2;
        cyc();
        hit_up = 4'h0;
        cyc();
        hit = 4'h0;
        trigger_at(9'd420, 5'd11);
        chain = 1'b1;
        trig_req = 5'd11;
        rd = 1'b1;
        #1;
        checks++; if (data_up !== 16'h0010) begin $display("FAIL chain_up_data: got %h want 0010", data_up); errors++; end
        checks++; if (data_dn !== 16'h0000) begin $display("FAIL chain_dn_blocked: got %h want 0000", data_dn); errors++; end
        checks++; if (tok_out !== 1'b1) begin $display("FAIL chain_dn_tok: got %b want 1", tok_out); errors++; end
        cyc();
        checks++; if (tok_up !== 1'b0) begin $display("FAIL chain_up_freed: got %b want 0", tok_up); errors++; end
        checks++; if (data_dn !== 16'h0002) begin $display("FAIL chain_dn_data: got %h want 0002", data_dn); errors++; end
        cyc();
        rd = 1'b0;
        chain = 1'b0;
        checks++; if (tok_out !== 1'b0) begin $display("FAIL chain_dn_freed: got %b want 0", tok_out); errors++; end
    endtask

    task automatic test_wrap();
        lat_req = 9'd5;
        run_to(9'd510);
        hit = 4'h8;
        cyc();
        hit = 4'h0;
        trigger_at(9'd3, 5'd21);
        trig_req = 5'd21;
        rd = 1'b1;
        #1;
        checks++; if (tok_out !== 1'b1) begin $display("FAIL wrap_pend: got %b want 1", tok_out); errors++; end
        checks++; if (data_dn !== 16'h1000) begin $display("FAIL wrap_data: got %h want 1000", data_dn); errors++; end
        cyc();
        rd = 1'b0;
        checks++; if (tok_out !== 1'b0) begin $display("FAIL wrap_freed: got %b want 0", tok_out); errors++; end
    endtask

    initial begin
        test_reset();
        test_single_hit();
        test_expiry();
        test_shared_slot();
        test_full();
        test_saturate();
        test_pwrdwn();
        test_back_to_back_chain();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
